// File: rtl/ram_datos_arbiter.sv
// ram_datos_arbiter
//
// Round-robin arbiter and access sequencer between two requesters (A: CPU
// data port, B: loader/DMA port) and a 1024x8 single-read-port data RAM.
// One transaction is in flight at a time; each runs IDLE -> ACCESS -> SETTLE
// -> DONE -> IDLE, so the RAM sees one access per four cycles at most.
//
// Ports
//   Clock, Reset            system clock, asynchronous active-low reset
//   iReqX/iWeX/iAddrX/iDataX request, write flag, address, write data (X=A,B)
//   oAckX                   one-cycle completion pulse in DONE
//   oRdDataX                last word read by port X (held until next read)
//   oBusy                   high whenever the sequencer is not in IDLE
//   oMemEnable, oWriteDataEnable, oReadDataAddress, oWriteDataAddress,
//   oDataMemIn              registered RAM-side drive
//   iDataMemOut             RAM read data
//   oDbgState               current sequencer state (IDLE=0, ACCESS=1,
//                           SETTLE=2, DONE=3)
//
// Handshake: a requester raises iReqX with iWeX/iAddrX/iDataX stable and keeps
// them until oAckX pulses; fields are captured only at the grant edge. iReqX
// must be low in the cycle after oAckX, otherwise it counts as a new request.

module ram_datos_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iReqA,
    input  logic                  iReqB,
    input  logic                  iWeA,
    input  logic                  iWeB,
    input  logic [ADDR_WIDTH-1:0] iAddrA,
    input  logic [ADDR_WIDTH-1:0] iAddrB,
    input  logic [DATA_WIDTH-1:0] iDataA,
    input  logic [DATA_WIDTH-1:0] iDataB,
    output logic                  oAckA,
    output logic                  oAckB,
    output logic [DATA_WIDTH-1:0] oRdDataA,
    output logic [DATA_WIDTH-1:0] oRdDataB,
    output logic                  oBusy,
    output logic                  oMemEnable,
    output logic                  oWriteDataEnable,
    output logic [ADDR_WIDTH-1:0] oReadDataAddress,
    output logic [ADDR_WIDTH-1:0] oWriteDataAddress,
    output logic [DATA_WIDTH-1:0] oDataMemIn,
    input  logic [DATA_WIDTH-1:0] iDataMemOut,
    output logic [1:0]            oDbgState
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_q;
    logic                  sel_b_q;   // winner of the current transaction
    logic                  we_q;
    logic                  last_b_q;  // 1 = B was granted last, so A wins a tie
    logic                  mem_en_q;
    logic                  wde_q;
    logic                  ack_a_q;
    logic                  ack_b_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rd_a_q;
    logic [DATA_WIDTH-1:0] rd_b_q;

    logic                  grant_d;
    logic                  sel_b_d;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] data_d;

    // B wins when it is the only requester, or on a tie when A went last.
    always_comb begin
        grant_d = iReqA | iReqB;
        sel_b_d = iReqB & (~iReqA | ~last_b_q);
        we_d    = sel_b_d ? iWeB   : iWeA;
        addr_d  = sel_b_d ? iAddrB : iAddrA;
        data_d  = sel_b_d ? iDataB : iDataA;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            sel_b_q  <= 1'b0;
            we_q     <= 1'b0;
            last_b_q <= 1'b1;
            mem_en_q <= 1'b0;
            wde_q    <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    mem_en_q <= 1'b0;
                    wde_q    <= 1'b0;
                    if (grant_d) begin
                        // ACCESS-cycle RAM drive is loaded at the grant edge.
                        sel_b_q  <= sel_b_d;
                        we_q     <= we_d;
                        addr_q   <= addr_d;
                        wdata_q  <= data_d;
                        mem_en_q <= 1'b1;
                        wde_q    <= we_d;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Dropping the write enable refreshes the RAM read port.
                    wde_q   <= 1'b0;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    mem_en_q <= 1'b0;
                    if (!we_q) begin
                        if (sel_b_q) rd_b_q <= iDataMemOut;
                        else         rd_a_q <= iDataMemOut;
                    end
                    ack_a_q  <= ~sel_b_q;
                    ack_b_q  <= sel_b_q;
                    last_b_q <= sel_b_q;
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oAckA             = ack_a_q;
    assign oAckB             = ack_b_q;
    assign oRdDataA          = rd_a_q;
    assign oRdDataB          = rd_b_q;
    assign oBusy             = (state_q != IDLE);
    assign oMemEnable        = mem_en_q;
    assign oWriteDataEnable  = wde_q;
    assign oReadDataAddress  = addr_q;
    assign oWriteDataAddress = addr_q;
    assign oDataMemIn        = wdata_q;
    assign oDbgState         = state_q;

endmodule

// File: tb/tb_ram_datos_arbiter.sv
// Directed bench for ram_datos_arbiter with a behavioural 1024x8 RAM attached.
module tb_ram_datos_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iReqA = 1'b0, iReqB = 1'b0, iWeA = 1'b0, iWeB = 1'b0;
    logic [9:0] iAddrA = '0, iAddrB = '0;
    logic [7:0] iDataA = '0, iDataB = '0;
    logic       oAckA, oAckB, oBusy, oMemEnable, oWriteDataEnable;
    logic [7:0] oRdDataA, oRdDataB, oDataMemIn;
    logic [9:0] oReadDataAddress, oWriteDataAddress;
    logic [1:0] oDbgState;
    logic [7:0] ram_dout = '0;
    logic [7:0] mem [1024] = '{default: 8'h00};

    ram_datos_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
        .Clock(clk), .Reset(rst_n),
        .iReqA(iReqA), .iReqB(iReqB), .iWeA(iWeA), .iWeB(iWeB),
        .iAddrA(iAddrA), .iAddrB(iAddrB), .iDataA(iDataA), .iDataB(iDataB),
        .oAckA(oAckA), .oAckB(oAckB), .oRdDataA(oRdDataA), .oRdDataB(oRdDataB),
        .oBusy(oBusy), .oMemEnable(oMemEnable), .oWriteDataEnable(oWriteDataEnable),
        .oReadDataAddress(oReadDataAddress), .oWriteDataAddress(oWriteDataAddress),
        .oDataMemIn(oDataMemIn), .iDataMemOut(ram_dout), .oDbgState(oDbgState)
    );

    // Single-read-port RAM: synchronous write, registered read when not writing.
    always @(posedge clk) begin
        if (oMemEnable) begin
            if (oWriteDataEnable) mem[oWriteDataAddress] <= oDataMemIn;
            else                  ram_dout <= mem[oReadDataAddress];
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd_a_exp = '0;
    logic [7:0] rd_b_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {oAckA, oAckB, oRdDataA, oRdDataB, oBusy, oMemEnable, oWriteDataEnable,
                oReadDataAddress, oWriteDataAddress, oDataMemIn, oDbgState};
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge while the DUT is IDLE; returns at a later IDLE negedge.
    // For reads, 'data' is the word the port is expected to return.
    task automatic run_txn(input bit port_b, input bit we, input logic [9:0] addr,
                           input logic [7:0] data, input string tag);
        int n = 0;
        int other_ack = 0;
        logic [15:0] wde_mask = '0;
        bit got = 1'b0;
        if (port_b) begin iReqB = 1'b1; iWeB = we; iAddrB = addr; iDataB = data; end
        else        begin iReqA = 1'b1; iWeA = we; iAddrA = addr; iDataA = data; end
        if (!we) exp_q.push_back(data);
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (oWriteDataEnable) wde_mask[n] = 1'b1;
            if (port_b ? oAckA : oAckB) other_ack++;
            got = port_b ? oAckB : oAckA;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_wde_cycles"}, wde_mask, we ? 16'h0002 : 16'h0000);
        check({tag, "_other_ack"}, other_ack, 0);
        if (port_b) iReqB = 1'b0; else iReqA = 1'b0;
        if (!we && exp_q.size() > 0) begin
            if (port_b) rd_b_exp = exp_q.pop_front();
            else        rd_a_exp = exp_q.pop_front();
        end
        check({tag, "_rd_a"}, oRdDataA, rd_a_exp);
        check({tag, "_rd_b"}, oRdDataB, rd_b_exp);
        @(negedge clk);
        check({tag, "_idle_after"}, {oBusy, oAckA, oAckB, oMemEnable}, 4'b0000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ack_a_mask;
        logic [15:0] ack_b_mask;
        logic [15:0] busy_low_mask;
        int overlap;

        // Reset state, with both ports already requesting writes.
        iReqA = 1'b1; iWeA = 1'b1; iAddrA = 10'h000; iDataA = 8'h11;
        iReqB = 1'b1; iWeB = 1'b1; iAddrB = 10'h001; iDataB = 8'h22;
        repeat (2) @(negedge clk);
        check("reset_outputs", all_outputs(), 64'h0);

        // Contention: grants alternate A,B,A,B with acks four cycles apart.
        rst_n = 1'b1;
        ack_a_mask = '0; ack_b_mask = '0; overlap = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (oAckA) ack_a_mask[c] = 1'b1;
            if (oAckB) ack_b_mask[c] = 1'b1;
            if (oAckA && oAckB) overlap++;
        end
        iReqA = 1'b0; iReqB = 1'b0;
        check("cont_ack_a", ack_a_mask, 16'h0808);
        check("cont_ack_b", ack_b_mask, 16'h8080);
        check("cont_overlap", overlap, 0);
        @(negedge clk);
        check("cont_idle", oBusy, 1'b0);

        // Write then read at the top address.
        run_txn(1'b0, 1'b1, 10'h3FF, 8'hA5, "a_wr_3ff");
        run_txn(1'b0, 1'b0, 10'h3FF, 8'hA5, "a_rd_3ff");

        // Port isolation: B read leaves A's data; A write leaves A's data.
        run_txn(1'b1, 1'b0, 10'h001, 8'h22, "b_rd_001");
        run_txn(1'b0, 1'b1, 10'h002, 8'h33, "a_wr_002");
        run_txn(1'b1, 1'b0, 10'h000, 8'h11, "b_rd_000");

        // Late field change after grant must not reach the RAM.
        iReqA = 1'b1; iWeA = 1'b1; iAddrA = 10'h010; iDataA = 8'h5A;
        @(negedge clk);
        iDataA = 8'hFF;
        check("late_access_din", {oWriteDataEnable, oDataMemIn}, {1'b1, 8'h5A});
        @(negedge clk);
        check("late_settle_din", {oMemEnable, oWriteDataEnable, oDataMemIn}, {2'b10, 8'h5A});
        @(negedge clk);
        check("late_ack", oAckA, 1'b1);
        iReqA = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 1'b0, 10'h010, 8'h5A, "a_rd_010");

        // Reset during ACCESS of a write: outputs clear at once, write is lost.
        run_txn(1'b1, 1'b1, 10'h020, 8'h44, "b_wr_020");
        iReqA = 1'b1; iWeA = 1'b1; iAddrA = 10'h020; iDataA = 8'h77;
        @(negedge clk);
        check("rst_mid_access_state", oDbgState, 2'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outputs", all_outputs(), 64'h0);
        iReqA = 1'b0;
        rd_a_exp = '0; rd_b_exp = '0;
        ack_a_mask = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (oAckA || oAckB) ack_a_mask[c] = 1'b1;
        end
        check("rst_mid_no_ack", ack_a_mask, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 1'b0, 10'h020, 8'h44, "a_rd_020_after_rst");

        // Held request: lone requester B wins back to back, one per 4 cycles.
        ack_b_mask = '0; busy_low_mask = '0;
        iReqB = 1'b1; iWeB = 1'b0; iAddrB = 10'h001; iDataB = 8'h00;
        if (!oBusy) busy_low_mask[0] = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (!oBusy) busy_low_mask[c] = 1'b1;
            if (oAckB) ack_b_mask[c] = 1'b1;
        end
        iReqB = 1'b0;
        check("held_ack_b", ack_b_mask, 16'h0888);
        check("held_busy_low", busy_low_mask, 16'h0111);
        check("held_rd_b", oRdDataB, 8'h22);
        check("held_rd_a", oRdDataA, 8'h44);
        @(negedge clk);
        check("final_idle", {oBusy, oDbgState}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_datos_arbiter.md
# ram_datos_arbiter

Two-requester arbiter and sequencer for the 1024×8 data RAM (`RAM_SINGLE_READ_PORT`). It sits between the CPU data port (port A) and the loader/DMA port (port B) on one side, and the RAM's enable, write-enable, address and data pins on the other. It grants one transaction at a time with round-robin fairness and drives the RAM through a fixed 4-cycle access sequence. It returns read data and a one-cycle acknowledge to the winning requester.

## Interface
- DATA_WIDTH, 8, data bits per word
- ADDR_WIDTH, 10, RAM address bits
- Clock  in  1  single system clock; all state changes on its rising edge
- Reset  in  1  asynchronous, active-low reset
- iReqA / iReqB  in  1  transaction request from port A / port B
- iWeA / iWeB  in  1  1 = write, 0 = read
- iAddrA / iAddrB  in  ADDR_WIDTH  target address
- iDataA / iDataB  in  DATA_WIDTH  write data
- oAckA / oAckB  out  1  one-cycle completion pulse
- oRdDataA / oRdDataB  out  DATA_WIDTH  last read result for that port
- oBusy  out  1  high in any state other than IDLE
- oMemEnable  out  1  to RAM memEnable
- oWriteDataEnable  out  1  to RAM iWriteDataEnable
- oReadDataAddress, oWriteDataAddress  out  ADDR_WIDTH  to RAM address inputs
- oDataMemIn  out  DATA_WIDTH  to RAM iDataMemIn
- iDataMemOut  in  DATA_WIDTH  from RAM oDataMemOut

## Operation
- Reset values: state=IDLE. Every output is 0, including both read-data registers and both RAM address buses. The priority pointer is set to B, so A wins the first contested grant.
- FSM: IDLE → ACCESS → SETTLE → DONE → IDLE. All RAM-side outputs are registered.
- IDLE:
  - Memory outputs: oMemEnable=0, oWriteDataEnable=0.
  - If exactly one iReq is high, that port wins.
  - If both are high, the port not granted last wins.
  - On a grant, latch the winner's id, we, addr and data, then go to ACCESS. With no request, stay in IDLE.
- ACCESS (1 cycle):
  - oMemEnable=1.
  - oReadDataAddress and oWriteDataAddress both equal the latched addr.
  - oDataMemIn equals the latched data.
  - oWriteDataEnable equals the latched we.
- SETTLE (1 cycle):
  - oMemEnable=1 and the addresses are held.
  - oWriteDataEnable=0. This falling edge refreshes the RAM read output.
  - For a read, capture iDataMemOut at the end of this cycle.
- DONE (1 cycle):
  - oAck of the winner is 1.
  - For a read, that port's oRdData holds the captured word.
  - For a write, oRdData is unchanged.
  - The priority pointer is set to the winner. Next state is IDLE.
- Requester rules:
  - Hold iReq, iWe, iAddr and iData stable from assertion until the ack cycle.
  - Drop iReq in the cycle after the ack, or it is treated as a new request.
  - Fields are latched only at grant, so changes after grant do not affect the current transaction.
- oRdDataX holds its value until the next completed read on port X.
- Address width is ADDR_WIDTH with no range check. All 2^ADDR_WIDTH addresses are valid, and there is no wrap logic.

## Timing
- Latency: a request sampled in IDLE at edge N gives ACCESS in cycle N+1, SETTLE in N+2 and ack in N+3 (DONE).
- Throughput: at most one transaction per 4 cycles. There is no back-to-back grant from DONE.
- A request that rises while oBusy=1 waits. It is arbitrated at the first IDLE cycle.
- Simultaneous requests alternate strictly: A, B, A, B…
- A lone requester may win repeatedly. The pointer only breaks ties.
- Reset asserted mid-transaction:
  - All outputs drop to 0 immediately (asynchronously), including oWriteDataEnable, so no write occurs after reset.
  - No ack is issued and the transaction is lost.
  - The requester re-requests after reset is released.
- Reset release: the first grant is possible at the first rising edge with Reset=1.
- oAckA and oAckB are never high together. oWriteDataEnable is never high outside ACCESS.

## Test plan
- Write then read: A writes 0xA5 to 0x3FF, then reads 0x3FF → oWriteDataEnable high exactly in the ACCESS cycle, oAckA at cycle +3, oRdDataA=0xA5.
- Contention: iReqA and iReqB both high from reset, A writes 0x11@0x000, B writes 0x22@0x001, each re-requesting → grant order A, B, A, B; acks 4 cycles apart; no overlapping acks.
- Port isolation: B reads 0x001 (0x22) → oRdDataB=0x22, oRdDataA keeps its prior value; a write by A leaves oRdDataA unchanged.
- Late field change: A requests a write of 0x5A@0x010 and changes iDataA to 0xFF in the ACCESS cycle → RAM location 0x010 reads 0x5A.
- Reset mid-ACCESS: Reset=0 during a write of 0x77@0x020 → all outputs are 0 immediately, no ack, state IDLE; after release, 0x020 still holds its old contents.
- Held request: iReqB held high through 3 transactions with iReqA low → three B acks at cycles 3, 7, 11; oBusy low only in cycles 0, 4 and 8.
